// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings for the sequencer, program counter and datapath
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_MEM    = 2'b10,
    ST_HALT   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    PCEN_HOLD = 2'b00,
    PCEN_INC  = 2'b01,
    PCEN_LOAD = 2'b10,
    PCEN_ADD  = 2'b11
  } pc_en_e;

  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MEMJ  = 4'b0100;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [15:0] INSTR_HALT = 16'hFFFF;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_UC = 4'b1110;

  // Bit positions inside the {Z,C,N,F,L} flag word.
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_F = 1;
  localparam int FLAG_L = 0;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_BCOND = 3'd1,
    CLS_JCOND = 3'd2,
    CLS_JAL   = 3'd3,
    CLS_LOAD  = 3'd4,
    CLS_STOR  = 3'd5,
    CLS_HALT  = 3'd6,
    CLS_NOP   = 3'd7
  } instr_class_e;

  // Halt wins over the ALU class that its all-ones opcode would otherwise select.
  function automatic instr_class_e classify(input logic [15:0] ir);
    instr_class_e cls;
    if (ir == INSTR_HALT) begin
      cls = CLS_HALT;
    end else if (ir[15:12] == OP_BCOND) begin
      cls = CLS_BCOND;
    end else if (ir[15:12] == OP_MEMJ) begin
      case (ir[7:4])
        EXT_LOAD:  cls = CLS_LOAD;
        EXT_STOR:  cls = CLS_STOR;
        EXT_JAL:   cls = CLS_JAL;
        EXT_JCOND: cls = CLS_JCOND;
        default:   cls = CLS_NOP;
      endcase
    end else begin
      cls = CLS_ALU;
    end
    return cls;
  endfunction

  function automatic logic [15:0] sext_disp(input logic [7:0] disp);
    return {{8{disp[7]}}, disp};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch/jump condition evaluator
module cond_eval
  import pc_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flags[FLAG_Z];
      COND_NE: taken = ~flags[FLAG_Z];
      COND_CS: taken = flags[FLAG_C];
      COND_CC: taken = ~flags[FLAG_C];
      COND_HI: taken = flags[FLAG_L];
      COND_LS: taken = ~flags[FLAG_L];
      COND_GT: taken = flags[FLAG_N];
      COND_LE: taken = ~flags[FLAG_N];
      COND_FS: taken = flags[FLAG_F];
      COND_FC: taken = ~flags[FLAG_F];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/memory control sequencer driving the PC and register file
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic [4:0]  flags,
  input  logic [15:0] rtarget,
  input  logic        memAck,
  output logic [1:0]  pcEn,
  output logic [15:0] newAdr,
  output logic [15:0] imm,
  output logic        memReq,
  output logic        memWe,
  output logic        addrSel,
  output logic        irLoad,
  output logic        regWrite,
  output logic        linkSel
);

  state_e       r_state;
  state_e       w_next_state;
  logic [15:0]  r_ir;
  instr_class_e w_class;
  logic [3:0]   w_cond;
  logic [7:0]   w_disp;
  logic         w_taken;

  assign w_class = classify(r_ir);
  assign w_cond  = r_ir[11:8];
  assign w_disp  = r_ir[7:0];

  cond_eval u_cond_eval (
    .cond  (w_cond),
    .flags (flags),
    .taken (w_taken)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (irLoad) begin
        r_ir <= instr;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    pcEn         = PCEN_HOLD;
    newAdr       = '0;
    imm          = '0;
    memReq       = 1'b0;
    memWe        = 1'b0;
    addrSel      = 1'b0;
    irLoad       = 1'b0;
    regWrite     = 1'b0;
    linkSel      = 1'b0;

    case (r_state)
      ST_FETCH: begin
        memReq = 1'b1;
        if (memAck) begin
          irLoad       = 1'b1;
          w_next_state = ST_DECODE;
        end
      end

      ST_DECODE: begin
        w_next_state = ST_FETCH;
        case (w_class)
          CLS_HALT: w_next_state = ST_HALT;
          CLS_ALU: begin
            regWrite = 1'b1;
            pcEn     = PCEN_INC;
          end
          CLS_BCOND: begin
            if (w_taken) begin
              pcEn = PCEN_ADD;
              imm  = sext_disp(w_disp);
            end else begin
              pcEn = PCEN_INC;
            end
          end
          CLS_JCOND: begin
            if (w_taken) begin
              pcEn   = PCEN_LOAD;
              newAdr = rtarget;
            end else begin
              pcEn = PCEN_INC;
            end
          end
          CLS_JAL: begin
            regWrite = 1'b1;
            linkSel  = 1'b1;
            newAdr   = rtarget;
            pcEn     = PCEN_LOAD;
          end
          CLS_LOAD, CLS_STOR: w_next_state = ST_MEM;
          default: pcEn = PCEN_INC;
        endcase
      end

      ST_MEM: begin
        memReq  = 1'b1;
        addrSel = 1'b1;
        memWe   = (w_class == CLS_STOR);
        if (memAck) begin
          regWrite     = (w_class == CLS_LOAD);
          pcEn         = PCEN_INC;
          w_next_state = ST_FETCH;
        end
      end

      default: w_next_state = ST_HALT;
    endcase

    // Outputs read as zero for the whole time reset is held, not just from the next edge.
    if (!reset_n) begin
      pcEn     = PCEN_HOLD;
      newAdr   = '0;
      imm      = '0;
      memReq   = 1'b0;
      memWe    = 1'b0;
      addrSel  = 1'b0;
      irLoad   = 1'b0;
      regWrite = 1'b0;
      linkSel  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic [15:0] instr;
  logic [4:0]  flags;
  logic [15:0] rtarget;
  logic        memAck;
  logic [1:0]  pcEn;
  logic [15:0] newAdr;
  logic [15:0] imm;
  logic        memReq;
  logic        memWe;
  logic        addrSel;
  logic        irLoad;
  logic        regWrite;
  logic        linkSel;

  int n_compared;
  int n_mismatched;

  logic [39:0] exp_q[$];
  string       tag_q[$];

  pc_sequencer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .instr    (instr),
    .flags    (flags),
    .rtarget  (rtarget),
    .memAck   (memAck),
    .pcEn     (pcEn),
    .newAdr   (newAdr),
    .imm      (imm),
    .memReq   (memReq),
    .memWe    (memWe),
    .addrSel  (addrSel),
    .irLoad   (irLoad),
    .regWrite (regWrite),
    .linkSel  (linkSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {pcEn,newAdr,imm,memReq,memWe,addrSel,irLoad,regWrite,linkSel}.
  function automatic logic [39:0] ex(input logic [1:0] pe, input logic [15:0] na,
                                     input logic [15:0] im, input logic rq, input logic we,
                                     input logic as, input logic il, input logic rw,
                                     input logic ls);
    return {pe, na, im, rq, we, as, il, rw, ls};
  endfunction

  function automatic logic cond_model(input logic [3:0] c, input logic [4:0] f);
    logic z, cy, n, ff, l;
    {z, cy, n, ff, l} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return l;
      4'h5: return !l;
      4'h6: return n;
      4'h7: return !n;
      4'h8: return ff;
      4'h9: return !ff;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_compared++;
    if (obs !== expv) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare on the falling edge.
  task automatic cyc(input logic [15:0] i_instr, input logic [4:0] i_flags,
                     input logic [15:0] i_rt, input logic i_ack,
                     input logic [39:0] e, input string tag);
    logic [39:0] e_pop;
    string       t_pop;
    instr   = i_instr;
    flags   = i_flags;
    rtarget = i_rt;
    memAck  = i_ack;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    e_pop = exp_q.pop_front();
    t_pop = tag_q.pop_front();
    check_eq(t_pop, {pcEn, newAdr, imm, memReq, memWe, addrSel, irLoad, regWrite, linkSel}, e_pop);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] i_instr, input string tag);
    cyc(i_instr, 5'h00, 16'h0000, 1'b1, ex(2'b00, 16'h0, 16'h0, 1, 0, 0, 1, 0, 0), tag);
  endtask

  initial begin
    logic [4:0]  f;
    logic [15:0] rt;
    logic [7:0]  d;
    logic        tk;
    n_compared   = 0;
    n_mismatched = 0;
    reset_n = 1'b0;
    instr   = '0;
    flags   = '0;
    rtarget = '0;
    memAck  = 1'b0;

    @(posedge clk);
    #1;
    cyc(16'h0123, 5'h1F, 16'hABCD, 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "reset_outputs");
    reset_n = 1'b1;

    // ALU with immediate ack; decode-time instr is junk to prove the latched copy is used.
    fetch(16'h0123, "alu_fetch");
    cyc(16'hFFFF, 5'h00, 16'h1234, 1'b0, ex(2'b01, 0, 0, 0, 0, 0, 0, 1, 0), "alu_decode");

    cyc(16'h0000, 5'h00, 16'h0000, 1'b0, ex(0, 0, 0, 1, 0, 0, 0, 0, 0), "fetch_wait");
    fetch(16'hC0FE, "bcond_z1_fetch");
    cyc(16'hFFFF, 5'b10000, 16'h0000, 1'b0, ex(2'b11, 0, 16'hFFFE, 0, 0, 0, 0, 0, 0), "bcond_z1");
    fetch(16'hC0FE, "bcond_z0_fetch");
    cyc(16'hFFFF, 5'b01111, 16'h0000, 1'b0, ex(2'b01, 0, 0, 0, 0, 0, 0, 0, 0), "bcond_z0");

    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 2; k++) begin
        f  = (k == 0) ? 5'($urandom) : ~f;
        d  = 8'($urandom);
        tk = cond_model(4'(c), f);
        fetch({4'hC, 4'(c), d}, "bsweep_fetch");
        cyc(16'hFFFF, f, 16'h0000, 1'b0,
            ex(tk ? 2'b11 : 2'b01, 0, tk ? {{8{d[7]}}, d} : 16'h0, 0, 0, 0, 0, 0, 0), "bsweep");
        rt = 16'($urandom);
        tk = cond_model(4'(c), f);
        fetch({4'h4, 4'(c), 4'hC, 4'h3}, "jsweep_fetch");
        cyc(16'hFFFF, f, rt, 1'b0,
            ex(tk ? 2'b10 : 2'b01, tk ? rt : 16'h0, 0, 0, 0, 0, 0, 0, 0), "jsweep");
      end
    end

    fetch(16'h4E83, "jal_fetch");
    cyc(16'hFFFF, 5'h00, 16'h0040, 1'b0, ex(2'b10, 16'h0040, 0, 0, 0, 0, 0, 1, 1), "jal");

    fetch(16'h4042, "stor_fetch");
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "stor_decode");
    for (int i = 0; i < 3; i++)
      cyc(16'hFFFF, 5'h00, 16'h0000, 1'b0, ex(0, 0, 0, 1, 1, 1, 0, 0, 0), "stor_wait");
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b1, ex(2'b01, 0, 0, 1, 1, 1, 0, 0, 0), "stor_ack");

    fetch(16'h4000, "load_fetch");
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "load_decode_stray_ack");
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b0, ex(0, 0, 0, 1, 0, 1, 0, 0, 0), "load_wait");
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b1, ex(2'b01, 0, 0, 1, 0, 1, 0, 1, 0), "load_ack");

    fetch(16'h4000, "rst_load_fetch");
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_load_decode");
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b0, ex(0, 0, 0, 1, 0, 1, 0, 0, 0), "rst_load_mem");
    reset_n = 1'b0;
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_mid_mem");
    reset_n = 1'b1;
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b0, ex(0, 0, 0, 1, 0, 0, 0, 0, 0), "post_rst_fetch");
    fetch(16'h0123, "post_rst_alu_fetch");
    cyc(16'hFFFF, 5'h00, 16'h0000, 1'b0, ex(2'b01, 0, 0, 0, 0, 0, 0, 1, 0), "post_rst_alu");

    fetch(16'hFFFF, "halt_fetch");
    cyc(16'h0123, 5'h1F, 16'h5555, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_decode");
    for (int i = 0; i < 20; i++)
      cyc(16'h0123, 5'h1F, 16'h5555, 1'($urandom), ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "halt_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
